// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result bundle between the execute-stage issuer and
// the alu_exec unit. The master drives the operation and operands; the slave
// (alu_exec) returns busy/done and the registered result.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       aluControl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluResult;
  logic             zero;

  modport master (
    output aluControl, srcA, srcB, start,
    input  busy, done, aluResult, zero
  );

  modport slave (
    input  aluControl, srcA, srcB, start,
    output busy, done, aluResult, zero
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: registered execution unit with a start/done handshake.
// add/sub/and/or/slt finish one cycle after the accepting edge; unused codes
// return 0 with the same latency. Define ALU_EXEC_MULT_EN to compile in an
// iterative shift-add multiplier (code 011, WIDTH+1 cycles latency, unsigned,
// low WIDTH bits kept). Without the macro code 011 acts as an unused code and
// busy is tied low.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_EXEC_MULT_EN
  localparam logic [2:0] OP_MUL = 3'b011;
`endif

  logic [WIDTH-1:0] w_alu_value;
  logic             w_slt;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic             r_zero;
  logic             w_zero_next;
  logic             r_done;
  logic             w_done_next;

  // Single-cycle datapath; anything not decoded (100, 101, and 011 when the
  // multiplier is absent) yields zero.
  always_comb begin
    w_alu_value = '0;
    w_slt       = $signed(bus.srcA) < $signed(bus.srcB);
    case (bus.aluControl)
      OP_ADD:  w_alu_value = bus.srcA + bus.srcB;
      OP_SUB:  w_alu_value = bus.srcA - bus.srcB;
      OP_AND:  w_alu_value = bus.srcA & bus.srcB;
      OP_OR:   w_alu_value = bus.srcA | bus.srcB;
      OP_SLT:  w_alu_value = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu_value = '0;
    endcase
  end

`ifdef ALU_EXEC_MULT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] w_mcand_next;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_mplier_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_acc_sum;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Next-state and datapath control. Only the low WIDTH bits of the product
  // are ever needed, so the accumulator and multiplicand stay WIDTH wide and
  // bits shifted out the top are simply dropped.
  always_comb begin
    w_state_next  = r_state;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_acc_next    = r_acc;
    w_count_next  = r_count;
    w_result_next = r_result;
    w_zero_next   = r_zero;
    w_done_next   = 1'b0;
    w_acc_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.aluControl == OP_MUL) begin
            w_mcand_next  = bus.srcA;
            w_mplier_next = bus.srcB;
            w_acc_next    = '0;
            w_count_next  = CNT_W'(WIDTH);
            w_state_next  = S_MUL;
          end else begin
            w_result_next = w_alu_value;
            w_zero_next   = (w_alu_value == '0);
            w_done_next   = 1'b1;
          end
        end
      end
      S_MUL: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        w_acc_next    = w_acc_sum;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_count_next  = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_result_next = w_acc_sum;
          w_zero_next   = (w_acc_sum == '0);
          w_done_next   = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Multiplier state register; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_acc    <= w_acc_next;
      r_count  <= w_count_next;
    end
  end

  assign bus.busy = (r_state == S_MUL);
`else
  // Without the multiplier every accepted request completes in one cycle.
  always_comb begin
    w_result_next = r_result;
    w_zero_next   = r_zero;
    w_done_next   = 1'b0;
    if (bus.start) begin
      w_result_next = w_alu_value;
      w_zero_next   = (w_alu_value == '0);
      w_done_next   = 1'b1;
    end
  end

  assign bus.busy = 1'b0;
`endif

  // Result/flag registers: result and zero hold between done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_result <= w_result_next;
      r_zero   <= w_zero_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.aluResult = r_result;
  assign bus.zero      = r_zero;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec. Multiply scenarios
// are selected when ALU_EXEC_MULT_EN is defined, the disabled-011 scenario
// otherwise.
module tb_alu_exec;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request: inputs are set, sampled at the next edge, then start
  // is dropped. Returns #1 after that edge, i.e. in the cycle where a
  // single-cycle result is valid.
  task automatic issue(input logic [2:0] code, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    bus.aluControl = code;
    bus.srcA       = a;
    bus.srcB       = b;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.aluResult !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_result: got %h expected %h", bus.aluResult, 32'd0);
    end
    n_checks++;
    if (bus.zero !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_zero: got %b expected 1", bus.zero);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    $display("reset: result=%h zero=%b done=%b busy=%b", bus.aluResult, bus.zero, bus.done, bus.busy);
  endtask

  task automatic test_back_to_back;
    // cycle 0: add 5+7 with start held
    bus.aluControl = 3'b010;
    bus.srcA       = 32'd5;
    bus.srcB       = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    // cycle 1: sub 3-3, start still high
    bus.aluControl = 3'b110;
    bus.srcA       = 32'd3;
    bus.srcB       = 32'd3;
    n_checks++;
    if (bus.aluResult !== 32'd12 || bus.zero !== 1'b0 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_add: got result=%h zero=%b done=%b expected result=0000000c zero=0 done=1",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("add 5+7: result=%h zero=%b done=%b", bus.aluResult, bus.zero, bus.done);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_sub: got result=%h zero=%b done=%b expected result=00000000 zero=1 done=1",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("sub 3-3: result=%h zero=%b done=%b", bus.aluResult, bus.zero, bus.done);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.aluResult !== 32'd0) begin
      n_errors++;
      $display("FAIL b2b_idle: got done=%b result=%h expected done=0 result=00000000",
               bus.done, bus.aluResult);
    end
  endtask

  task automatic test_slt;
    issue(3'b111, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if (bus.aluResult !== 32'd1 || bus.zero !== 1'b0 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL slt_neg_lt_pos: got result=%h zero=%b done=%b expected 00000001 0 1",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("slt -1<1: result=%h zero=%b", bus.aluResult, bus.zero);
    issue(3'b111, 32'd1, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL slt_pos_lt_neg: got result=%h zero=%b done=%b expected 00000000 1 1",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("slt 1<-1: result=%h zero=%b", bus.aluResult, bus.zero);
  endtask

  task automatic test_logic_wrap;
    issue(3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    n_checks++;
    if (bus.aluResult !== 32'h00F0_000F || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL and: got %h done=%b expected 00f0000f done=1", bus.aluResult, bus.done);
    end
    $display("and: result=%h", bus.aluResult);
    issue(3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    n_checks++;
    if (bus.aluResult !== 32'hFFF0_0FFF || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL or: got %h done=%b expected fff00fff done=1", bus.aluResult, bus.done);
    end
    $display("or: result=%h", bus.aluResult);
    issue(3'b010, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1) begin
      n_errors++;
      $display("FAIL add_wrap: got result=%h zero=%b expected 00000000 1", bus.aluResult, bus.zero);
    end
    $display("add wrap: result=%h zero=%b", bus.aluResult, bus.zero);
    issue(3'b110, 32'd0, 32'd1);
    n_checks++;
    if (bus.aluResult !== 32'hFFFF_FFFF || bus.zero !== 1'b0) begin
      n_errors++;
      $display("FAIL sub_wrap: got result=%h zero=%b expected ffffffff 0", bus.aluResult, bus.zero);
    end
    $display("sub wrap: result=%h zero=%b", bus.aluResult, bus.zero);
  endtask

  task automatic test_unused_codes;
    // Previous result is nonzero, so a zero here is a real update.
    issue(3'b100, 32'd9, 32'd4);
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL code100: got result=%h zero=%b done=%b expected 00000000 1 1",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("code 100: result=%h zero=%b done=%b", bus.aluResult, bus.zero, bus.done);
    issue(3'b010, 32'd1, 32'd1);
    issue(3'b101, 32'd9, 32'd4);
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL code101: got result=%h zero=%b done=%b expected 00000000 1 1",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("code 101: result=%h zero=%b done=%b", bus.aluResult, bus.zero, bus.done);
  endtask

  task automatic test_reset_after_op;
    issue(3'b010, 32'd2, 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_after_op: got result=%h zero=%b done=%b expected 00000000 1 0",
               bus.aluResult, bus.zero, bus.done);
    end
    $display("reset after add: result=%h zero=%b done=%b", bus.aluResult, bus.zero, bus.done);
  endtask

`ifdef ALU_EXEC_MULT_EN
  task automatic test_mul;
    int busy_errs;
    int done_count;
    busy_errs  = 0;
    done_count = 0;
    issue(3'b011, 32'd6, 32'd7);
    // cycles n+1 .. n+32: busy high, no done; an add 1+1 is offered mid-way
    for (int i = 1; i <= WIDTH; i++) begin
      if (bus.busy !== 1'b1) busy_errs++;
      if (bus.done === 1'b1) done_count++;
      if (i == 5) begin
        bus.aluControl = 3'b010;
        bus.srcA       = 32'd1;
        bus.srcB       = 32'd1;
        bus.start      = 1'b1;
      end
      if (i == 6) bus.start = 1'b0;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy_errs !== 0 || done_count !== 0) begin
      n_errors++;
      $display("FAIL mul_busy_window: busy low in %0d cycles, done seen %0d times, expected 0 and 0",
               busy_errs, done_count);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.aluResult !== 32'd42 || bus.zero !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_6x7: got done=%b result=%h zero=%b busy=%b expected 1 0000002a 0 0",
               bus.done, bus.aluResult, bus.zero, bus.busy);
    end
    $display("mul 6*7: done=%b result=%h busy=%b", bus.done, bus.aluResult, bus.busy);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.aluResult !== 32'd42 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_single_done: got done=%b result=%h busy=%b expected 0 0000002a 0",
               bus.done, bus.aluResult, bus.busy);
    end
    // low-bits truncation and zero flag: 0x10000 * 0x10000 = 2^32 -> 0
    issue(3'b011, 32'h0001_0000, 32'h0001_0000);
    repeat (WIDTH) @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.aluResult !== 32'd0 || bus.zero !== 1'b1) begin
      n_errors++;
      $display("FAIL mul_trunc_zero: got done=%b result=%h zero=%b expected 1 00000000 1",
               bus.done, bus.aluResult, bus.zero);
    end
    $display("mul 2^16*2^16: done=%b result=%h zero=%b", bus.done, bus.aluResult, bus.zero);
    // unsigned operands: 0xFFFFFFFF * 3 -> low bits 0xFFFFFFFD
    issue(3'b011, 32'hFFFF_FFFF, 32'd3);
    repeat (WIDTH) @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.aluResult !== 32'hFFFF_FFFD || bus.zero !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_unsigned: got done=%b result=%h zero=%b expected 1 fffffffd 0",
               bus.done, bus.aluResult, bus.zero);
    end
    $display("mul ffffffff*3: done=%b result=%h", bus.done, bus.aluResult);
  endtask

  task automatic test_reset_mid_mul;
    issue(3'b010, 32'd40, 32'd2);
    issue(3'b011, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_mul: got busy=%b result=%h zero=%b done=%b expected 0 00000000 1 0",
               bus.busy, bus.aluResult, bus.zero, bus.done);
    end
    $display("reset mid-mul: busy=%b result=%h zero=%b done=%b", bus.busy, bus.aluResult, bus.zero, bus.done);
    issue(3'b010, 32'd2, 32'd2);
    n_checks++;
    if (bus.done !== 1'b1 || bus.aluResult !== 32'd4 || bus.zero !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL add_after_reset: got done=%b result=%h zero=%b busy=%b expected 1 00000004 0 0",
               bus.done, bus.aluResult, bus.zero, bus.busy);
    end
    $display("add 2+2 after reset: result=%h done=%b", bus.aluResult, bus.done);
  endtask
`else
  task automatic test_mul_disabled;
    issue(3'b010, 32'd8, 32'd1);
    issue(3'b011, 32'd6, 32'd7);
    n_checks++;
    if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_disabled: got result=%h zero=%b done=%b busy=%b expected 00000000 1 1 0",
               bus.aluResult, bus.zero, bus.done, bus.busy);
    end
    $display("code 011 disabled: result=%h zero=%b done=%b busy=%b",
             bus.aluResult, bus.zero, bus.done, bus.busy);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_disabled_after: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask
`endif

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.aluControl = 3'b000;
    bus.srcA       = '0;
    bus.srcB       = '0;
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_slt;
    test_logic_wrap;
    test_unused_codes;
    test_reset_after_op;
`ifdef ALU_EXEC_MULT_EN
    test_mul;
    test_reset_mid_mul;
`else
    test_mul_disabled;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execution unit that consumes the 3-bit `aluControl` code from the ALU control decoder, together with two operands, and returns a result over a start/done handshake. Add, sub, and, or and slt complete in one cycle. An optional iterative shift-add multiplier takes `WIDTH` cycles. The block sits in the execute stage between the register-file read ports and the writeback/branch logic.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `aluControl`  in  3  operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul (only with `ALU_EXEC_MULT_EN`).
- `srcA`  in  WIDTH  operand A.
- `srcB`  in  WIDTH  operand B.
- `start`  in  1  request; sampled only when `busy`=0.
- `busy`  out  1  high while a multiply is iterating.
- `done`  out  1  one-cycle pulse; `aluResult` and `zero` are valid and freshly updated.
- `aluResult`  out  WIDTH  registered result; holds its value between `done` pulses.
- `zero`  out  1  registered; equals `aluResult == 0`; updates together with `aluResult`.

## Operation
- States: IDLE and MUL.
- Reset values: state=IDLE, `busy`=0, `done`=0, `aluResult`=0, `zero`=1.
- IDLE, with `start`=1 and a single-cycle code: compute the result, register it into `aluResult`/`zero`, set `done`=1 for the next cycle, and stay in IDLE.
- IDLE, with `start`=1 and code 011 (macro defined): latch `srcA`/`srcB`, clear the accumulator, load the counter with `WIDTH`, and go to MUL.
- MUL, each cycle:
  - if the multiplier LSB is 1, the accumulator += multiplicand;
  - shift the multiplicand left and the multiplier right;
  - decrement the counter.
- MUL, on the step where the counter reaches 0: write the low `WIDTH` bits of the product to `aluResult`, update `zero`, pulse `done`, and return to IDLE.
- Arithmetic:
  - add and sub wrap modulo 2^WIDTH; no overflow flag.
  - slt is a signed compare: result is 1 if `$signed(srcA) < $signed(srcB)`, else 0, zero-extended.
  - mul keeps only the low `WIDTH` bits of the product; operands are treated as unsigned.
- Codes 100 and 101, and 011 without the macro: result 0, `zero`=1, latency 1 (same as a single-cycle op).
- `start` while `busy`=1: ignored; no queueing, and `aluResult` is unaffected.
- `start` held high in IDLE: every cycle is a new request, so back-to-back single-cycle ops run one per cycle.
- `reset` in any state, including mid-multiply: the partial product is discarded and all outputs return to their reset values at the next edge.

## Timing
- Single-cycle op, `start` sampled at edge n:
  - `done`=1 and the result is valid during cycle n+1;
  - `busy` stays 0.
- Multiply, `start` sampled at edge n:
  - `busy`=1 during cycles n+1 through n+WIDTH;
  - `done`=1, the result is valid and `busy`=0 during cycle n+WIDTH+1 (latency WIDTH+1);
  - a new `start` is accepted in cycle n+WIDTH+1.
- `done` is never high for two consecutive cycles from the same request.
- `aluControl`, `srcA` and `srcB` need only be stable at the edge that accepts `start`.

## Configuration
- `ALU_EXEC_MULT_EN` defined:
  - the MUL state, counter and accumulator are compiled in;
  - code 011 performs the multiply described above.
- `ALU_EXEC_MULT_EN` undefined:
  - no MUL state; `busy` is tied to 0;
  - code 011 behaves as an unused code (result 0, latency 1).

## Test plan
- Add then sub back-to-back: cycle 0 `start`, 010, 5 and 7; cycle 1 `start`, 110, 3 and 3 -> `aluResult`=12, `zero`=0, `done`=1 in cycle 1; `aluResult`=0, `zero`=1, `done`=1 in cycle 2.
- slt sign handling: A=32'hFFFFFFFF, B=1 -> result 1; A=1, B=32'hFFFFFFFF -> result 0.
- And/or: A=32'hF0F0_00FF, B=32'h0FF0_0F0F -> and = 32'h00F0_000F, or = 32'hFFF0_0FFF; wrap: add 32'hFFFFFFFF + 1 -> 0 with `zero`=1.
- Multiply with macro: 6 * 7 -> `busy` high for 32 cycles, `done`=1 with `aluResult`=42 at latency 33. A `start` pulsed mid-busy with add 1+1 is ignored: exactly one `done`, result 42.
- Reset mid-multiply: assert `reset` at cycle 10 of a multiply -> next cycle `busy`=0, `aluResult`=0, `zero`=1, no `done`; a fresh add 2+2 then returns 4 with latency 1.
- Without macro: code 011 with A=6, B=7 -> `aluResult`=0, `zero`=1, `done` in the next cycle, `busy` never 1.
